// File: rtl/rsnn_timestep_scheduler_pkg.sv
// RSNN timestep scheduler shared types and default sizes.
// Pure declarations, no logic and no latency.
// No flow control: consumed by the scheduler and its bench.
package rsnn_pkg;

  // Timestep sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam int RSNN_NUM_NEURONS = 8;
  localparam int RSNN_NUM_INPUTS  = 8;
  localparam int STEP_CNT_W       = 8;

endpackage

// File: rtl/rsnn_timestep_scheduler.sv
// Sequences one RSNN timestep: one update request per neuron over a shared datapath.
// Latency: 2*NUM_NEURONS+2 cycles from start to done with a ready datapath and 1-cycle results.
// Backpressure: upd_valid holds until upd_ready; WAIT holds until res_valid, with no timeout.
module rsnn_timestep_scheduler
  import rsnn_pkg::*;
#(
  parameter int NUM_NEURONS = RSNN_NUM_NEURONS,
  parameter int NUM_INPUTS  = RSNN_NUM_INPUTS,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  clear,
  input  logic [NUM_INPUTS-1:0] in_spikes,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [IDX_W-1:0]      upd_idx,
  output logic                  upd_first,
  output logic [NUM_INPUTS-1:0] upd_in_spikes,
  output logic [NUM_NEURONS-1:0] upd_rec_spikes,
  input  logic                  res_valid,
  input  logic                  res_spike,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_NEURONS-1:0] spikes_out,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [STEP_CNT_W-1:0] CNT_ONE  = STEP_CNT_W'(1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_INPUTS-1:0]   in_lat_q, in_lat_d;
  logic [NUM_NEURONS-1:0]  scratch_q, scratch_d;
  logic [NUM_NEURONS-1:0]  spikes_q, spikes_d;
  logic [STEP_CNT_W-1:0]   step_q, step_d;
  logic                    done_q, done_d;
  logic                    upd_valid_q, upd_valid_d;
  logic                    upd_first_q, upd_first_d;
  logic                    busy_q, busy_d;

  // Next-state and registered-output computation for the timestep sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_lat_d    = in_lat_q;
    scratch_d   = scratch_q;
    spikes_d    = spikes_q;
    step_d      = step_q;
    done_d      = 1'b0;
    upd_valid_d = upd_valid_q;
    upd_first_d = upd_first_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        // start takes priority over clear; clear is simply dropped
        if (ena && start) begin
          in_lat_d    = in_spikes;
          idx_d       = '0;
          state_d     = ISSUE;
          upd_valid_d = 1'b1;
          upd_first_d = 1'b1;
          busy_d      = 1'b1;
        end else if (ena && clear) begin
          spikes_d = '0;
          step_d   = '0;
        end
      end
      ISSUE: begin
        if (upd_ready) begin
          state_d     = WAIT;
          upd_valid_d = 1'b0;
          upd_first_d = 1'b0;
        end
      end
      WAIT: begin
        // Result for the outstanding index; the handshake cycle never reaches here
        if (res_valid) begin
          scratch_d[idx_q] = res_spike;
          if (idx_q == IDX_LAST) begin
            state_d = COMMIT;
          end else begin
            idx_d       = idx_q + IDX_ONE;
            state_d     = ISSUE;
            upd_valid_d = 1'b1;
            upd_first_d = 1'b0;
          end
        end
      end
      COMMIT: begin
        // Atomic update: the recurrent input only changes here or on clear
        spikes_d = scratch_q;
        step_d   = step_q + CNT_ONE;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d     = IDLE;
        upd_valid_d = 1'b0;
        upd_first_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any step without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_lat_q    <= '0;
      scratch_q   <= '0;
      spikes_q    <= '0;
      step_q      <= '0;
      done_q      <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_first_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_lat_q    <= in_lat_d;
      scratch_q   <= scratch_d;
      spikes_q    <= spikes_d;
      step_q      <= step_d;
      done_q      <= done_d;
      upd_valid_q <= upd_valid_d;
      upd_first_q <= upd_first_d;
      busy_q      <= busy_d;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_idx        = idx_q;
  assign upd_first      = upd_first_q;
  assign upd_in_spikes  = in_lat_q;
  assign upd_rec_spikes = spikes_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign spikes_out     = spikes_q;
  assign step_count     = step_q;

endmodule

// File: tb/tb_rsnn_timestep_scheduler.sv
// Directed bench for the RSNN timestep scheduler with a cycle-by-cycle datapath model.
// Checks step latency, ordering, stalls, recurrence, wrap, clear/enable and reset abort.
// Datapath responses arrive one cycle after each handshake unless stalled.
module tb_rsnn_timestep_scheduler;
  import rsnn_pkg::*;

  localparam int N  = 8;
  localparam int NI = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena, start, clear;
  logic [NI-1:0] in_spikes;
  logic          upd_valid, upd_ready;
  logic [IW-1:0] upd_idx;
  logic          upd_first;
  logic [NI-1:0] upd_in_spikes;
  logic [N-1:0]  upd_rec_spikes;
  logic          res_valid, res_spike;
  logic          busy, done;
  logic [N-1:0]  spikes_out;
  logic [7:0]    step_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rsnn_timestep_scheduler #(.NUM_NEURONS(N), .NUM_INPUTS(NI), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .clear(clear),
    .in_spikes(in_spikes), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_idx(upd_idx), .upd_first(upd_first), .upd_in_spikes(upd_in_spikes),
    .upd_rec_spikes(upd_rec_spikes), .res_valid(res_valid), .res_spike(res_spike),
    .busy(busy), .done(done), .spikes_out(spikes_out), .step_count(step_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath spike rule per neuron index
  function automatic logic spike_of(input int mode, input int idx);
    case (mode)
      0:       return (idx % 2) == 1;
      1:       return 1'b1;
      2:       return 1'b0;
      default: return (idx % 2) == 0;
    endcase
  endfunction

  // Runs one step; done_cyc = cycle in which done is seen (0 if aborted by reset)
  task automatic do_step(input logic [7:0] spk, input int mode, input int stall_idx,
                         input int stall_n, input bit with_clear, input int busy_start,
                         input bit spur, input int abort_idx, input logic [7:0] exp_rec,
                         output int done_cyc);
    int stall_left, expect_idx, pend_idx;
    bit pending, prev_stall;
    @(negedge clk);
    ena = 1'b1; start = 1'b1; clear = with_clear; in_spikes = spk;
    upd_ready = 1'b0; res_valid = 1'b0; res_spike = 1'b0;
    @(posedge clk);
    done_cyc = -1; stall_left = stall_n; expect_idx = 0; pend_idx = 0;
    pending = 1'b0; prev_stall = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = (cyc == busy_start); clear = 1'b0; in_spikes = ~spk;
      if (done) begin
        done_cyc = cyc;
        start = 1'b0; upd_ready = 1'b0; res_valid = 1'b0;
        break;
      end
      chk("busy_in_step", busy, 1);
      chk("rec_spikes", upd_rec_spikes, exp_rec);
      if (prev_stall) chk("hold_valid", upd_valid, 1);
      res_valid = pending | (spur & upd_valid);
      res_spike = pending ? spike_of(mode, pend_idx) : 1'b1;
      pending = 1'b0; prev_stall = 1'b0; upd_ready = 1'b0;
      if (upd_valid) begin
        chk("upd_idx", upd_idx, expect_idx);
        chk("upd_first", upd_first, (expect_idx == 0));
        chk("upd_in_spikes", upd_in_spikes, spk);
        if (abort_idx == expect_idx) begin
          rst_n = 1'b0; upd_ready = 1'b0; res_valid = 1'b0; start = 1'b0;
          #1;
          chk("rst_valid", upd_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_spikes", spikes_out, 0);
          chk("rst_count", step_count, 0);
          chk("rst_idx", upd_idx, 0);
          chk("rst_first", upd_first, 0);
          chk("rst_in_lat", upd_in_spikes, 0);
          @(negedge clk);
          rst_n = 1'b1;
          done_cyc = 0;
          return;
        end
        if (expect_idx == stall_idx && stall_left > 0) begin
          stall_left--;
          prev_stall = 1'b1;
        end else begin
          upd_ready = 1'b1; pending = 1'b1; pend_idx = expect_idx; expect_idx++;
        end
      end
      @(posedge clk);
    end
    start = 1'b0; upd_ready = 1'b0; res_valid = 1'b0;
    if (done_cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL step_timeout: got no done expected done within 200 cycles");
    end else begin
      chk("issued_all", expect_idx, N);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("done_single", done, 0);
        chk("idle_after", busy, 0);
      end
    end
  endtask

  typedef struct {
    logic [7:0] spk;
    int         mode;
    int         stall_idx;
    int         stall_n;
    bit         with_clear;
    int         busy_start;
    bit         spur;
    int         exp_done;
    logic [7:0] exp_spikes;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] rec;
  int         dc;
  int         seen_done;

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          spk    mode stall_i n  clr  bstart spur done spikes cnt
    tbl[0] = '{8'hA5, 0,   -1,     0, 1'b0, 0,    1'b0, 18, 8'hAA, 8'd1};
    tbl[1] = '{8'h3C, 1,    2,     3, 1'b0, 0,    1'b0, 21, 8'hFF, 8'd2};
    tbl[2] = '{8'h00, 2,    4,     2, 1'b0, 0,    1'b1, 20, 8'h00, 8'd3};
    tbl[3] = '{8'hFF, 3,    7,     2, 1'b0, 0,    1'b0, 20, 8'h55, 8'd4};
    tbl[4] = '{8'h5A, 1,   -1,     0, 1'b1, 0,    1'b0, 18, 8'hFF, 8'd5};
    tbl[5] = '{8'hC3, 0,   -1,     0, 1'b0, 5,    1'b0, 18, 8'hAA, 8'd6};

    rst_n = 1'b0; ena = 1'b0; start = 1'b0; clear = 1'b0; in_spikes = '0;
    upd_ready = 1'b0; res_valid = 1'b0; res_spike = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", upd_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_spikes", spikes_out, 0);
    chk("reset_count", step_count, 0);
    chk("reset_first", upd_first, 0);
    rst_n = 1'b1;

    rec = 8'h00;
    for (int i = 0; i < 6; i++) begin
      do_step(tbl[i].spk, tbl[i].mode, tbl[i].stall_idx, tbl[i].stall_n,
              tbl[i].with_clear, tbl[i].busy_start, tbl[i].spur, -1, rec, dc);
      chk($sformatf("v%0d_done_cycle", i), dc, tbl[i].exp_done);
      chk($sformatf("v%0d_spikes", i), spikes_out, tbl[i].exp_spikes);
      chk($sformatf("v%0d_count", i), step_count, tbl[i].exp_cnt);
      rec = tbl[i].exp_spikes;
    end

    // clear without enable is ignored
    @(negedge clk); ena = 1'b0; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_noena_spikes", spikes_out, 8'hAA);
    chk("clear_noena_count", step_count, 6);

    // clear with enable zeroes state
    ena = 1'b1; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_spikes", spikes_out, 0);
    chk("clear_count", step_count, 0);

    // start without enable does nothing
    ena = 1'b0; start = 1'b1; in_spikes = 8'hFF;
    @(negedge clk); start = 1'b0;
    chk("noena_busy", busy, 0);
    @(negedge clk);
    chk("noena_busy2", busy, 0);
    chk("noena_valid", upd_valid, 0);
    ena = 1'b1;

    // recurrence and 8-bit wrap over 256 all-spiking steps
    for (int s = 1; s <= 256; s++) begin
      do_step(8'h0F, 1, -1, 0, 1'b0, 0, 1'b0, -1, (s == 1) ? 8'h00 : 8'hFF, dc);
      if (s == 1 || s == 256) chk($sformatf("wrap_done_cycle_s%0d", s), dc, 18);
      if (s == 255) chk("wrap_count_255", step_count, 255);
    end
    chk("wrap_count_0", step_count, 0);
    chk("wrap_spikes", spikes_out, 8'hFF);

    // reset in the middle of a step (at idx 3)
    do_step(8'h81, 0, -1, 0, 1'b0, 0, 1'b0, -1, 8'hFF, dc);
    chk("pre_rst_count", step_count, 1);
    do_step(8'h42, 1, -1, 0, 1'b0, 0, 1'b0, 3, 8'hAA, dc);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("no_done_after_rst", seen_done, 0);
    chk("post_rst_busy", busy, 0);
    do_step(8'h99, 0, -1, 0, 1'b0, 0, 1'b0, -1, 8'h00, dc);
    chk("post_rst_done_cycle", dc, 18);
    chk("post_rst_spikes", spikes_out, 8'hAA);
    chk("post_rst_count", step_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
